// File: rtl/fp_mul_arbiter_pkg.sv
// fp_arb_pkg: word type, tag record and id-width helper shared by the
// fp_mul_arbiter slice.
package fp_arb_pkg;

  localparam int FP_W     = 32;
  // Tag id field is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if: requester-side bus of the shared multiplier arbiter.
// master = the FPU clients, slave = the arbiter.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import fp_arb_pkg::*;

  localparam int IW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*FP_W-1:0] req_a;
  logic [NUM_REQ*FP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  fp_word_t                rsp_data;
  logic [IW-1:0]           rsp_id;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/fp_mul_arbiter_rr_grant.sv
// rr_grant: combinational one-hot grant. Scans from ptr upward with wrap;
// with FP_ARB_FIXED_PRIO_EN defined the scan always starts at index 0.
module rr_grant
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      gnt_id
);

  // first valid index at or after the start point wins
  always_comb begin : scan
    logic [IW:0]   pos;
    logic [IW-1:0] start;
    logic          found;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    pos    = '0;
`ifdef FP_ARB_FIXED_PRIO_EN
    start  = '0;
`else
    start  = ptr;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ)) pos = pos - (IW+1)'(NUM_REQ);
      if (!found && req[pos[IW-1:0]]) begin
        found              = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        gnt_id             = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one pipelined FP multiplier among NUM_REQ clients.
// One operand pair issued per cycle, requester id carried alongside the
// multiplier in a MUL_LAT-deep tag pipe, result routed back to its owner.
// Build option: FP_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority
// and removes the round-robin pointer.
module fp_mul_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  fp_mul_arbiter_if.slave   cli,
  output logic              mul_valid,
  output fp_word_t          mul_a,
  output fp_word_t          mul_b,
  input  fp_word_t          mul_res,
  output logic              busy
);

  localparam int IW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gnt_id;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      issue_id;
  fp_word_t           sel_a;
  fp_word_t           sel_b;
  tag_t               tags [MUL_LAT];
  logic               any_tag;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_grant (
    .req    (cli.req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign cli.req_ready = rst ? '0 : grant;

`ifdef FP_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // pointer moves just past the winner, holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (|grant)  ptr <= (gnt_id == IW'(NUM_REQ-1)) ? '0 : gnt_id + IW'(1);
  end
`endif

  // grant is one-hot, so OR-ing the masked lanes selects the winner
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | cli.req_a[i*FP_W +: FP_W];
        sel_b = sel_b | cli.req_b[i*FP_W +: FP_W];
      end
    end
  end

  // issue stage: operands hold when idle so the multiplier inputs stay quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_id  <= '0;
    end else begin
      mul_valid <= |grant;
      if (|grant) begin
        mul_a    <= sel_a;
        mul_b    <= sel_b;
        issue_id <= gnt_id;
      end
    end
  end

  // tag pipe tracks the multiplier's own latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0].valid <= mul_valid;
      tags[0].id    <= ID_MAX_W'(issue_id);
      for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  // route the product to the owner; data/id hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      cli.rsp_valid <= '0;
      cli.rsp_data  <= '0;
      cli.rsp_id    <= '0;
    end else if (tags[MUL_LAT-1].valid) begin
      cli.rsp_valid <= NUM_REQ'(1) << tags[MUL_LAT-1].id;
      cli.rsp_data  <= mul_res;
      cli.rsp_id    <= tags[MUL_LAT-1].id[IW-1:0];
    end else begin
      cli.rsp_valid <= '0;
    end
  end

  // anything between issue and response keeps the block busy
  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) any_tag = any_tag | tags[i].valid;
  end

  assign busy = mul_valid | any_tag;

endmodule
